// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush control for load-use, taken branches and slow data memory.
module pipe_hazard_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_USES_RT,
  input  logic        EX_MEMREAD,
  input  logic [4:0]  EX_REG_DEST,
  input  logic        MEM_BRANCH_TAKEN,
  input  logic        MEM_REQ,
  input  logic        MEM_READY,
  output logic        PC_EN,
  output logic        IFID_EN,
  output logic        IDEX_EN,
  output logic        EXMEM_EN,
  output logic        IFID_FLUSH,
  output logic        IDEX_FLUSH,
  output logic        EXMEM_FLUSH,
  output logic        MEM_BUSY,
  output logic        MEM_TIMEOUT,
  output logic [15:0] STALL_COUNT
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;
  state_t state, next_state;
  logic [7:0] wait_cnt;
  logic load_use, mem_stall, wait_low;
  assign load_use  = EX_MEMREAD && EX_REG_DEST != 5'd0 &&
                     (EX_REG_DEST == ID_RS || (ID_USES_RT && EX_REG_DEST == ID_RT));
  assign mem_stall = MEM_REQ && !MEM_READY;
  assign wait_low  = state == MEM_WAIT && !MEM_READY;
  always_comb begin
    {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN} = 4'b1111;
    {IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH} = 3'b000;
    MEM_BUSY = 1'b0;
    next_state = state;
    if (RESET) begin
      {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN} = 4'b0000;
      {IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH} = 3'b111;
      next_state = RUN;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN} = 4'b0000;
            MEM_BUSY = 1'b1;
            next_state = MEM_WAIT;
          end else if (MEM_BRANCH_TAKEN) begin
            {IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH} = 3'b111;
            next_state = FLUSH;
          end else if (load_use) begin
            {PC_EN, IFID_EN} = 2'b00;
            IDEX_FLUSH = 1'b1;
          end
        end
        MEM_WAIT: begin
          // branch is ignored here; EX/MEM holds it until release
          MEM_BUSY = 1'b1;
          {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN} = MEM_READY ? 4'b1111 : 4'b0000;
          next_state = MEM_READY ? RUN : MEM_WAIT;
        end
        FLUSH: begin
          IFID_FLUSH = 1'b1;
          next_state = RUN;
        end
        default: next_state = RUN;
      endcase
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      MEM_TIMEOUT <= 1'b0;
      STALL_COUNT <= 16'd0;
    end else begin
      state       <= next_state;
      wait_cnt    <= wait_low ? (wait_cnt == 8'hFF ? wait_cnt : wait_cnt + 8'd1) : 8'd0;
      MEM_TIMEOUT <= MEM_TIMEOUT | (wait_low && wait_cnt == 8'hFF);
      if (!PC_EN && STALL_COUNT != 16'hFFFF) STALL_COUNT <= STALL_COUNT + 16'd1;
    end
  end
endmodule
